logic_gate_pipe: RTL

//  Parametrised, pipelined successor to the lab 2-input gate cells.

---
 rtl/logic_gate_pipe.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe
//   Two-stage valid/ready pipeline that reduces NUM_IN operands of WIDTH bits
//   with a selectable bitwise gate (AND/OR/XOR/NAND/NOR/XNOR), plus two sticky
//   accumulate modes (ACC_OR, ACC_XOR) that fold the reduction into an
//   internal accumulator.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   in_valid   input transaction valid
//   in_ready   block can accept this cycle (combinational from out_ready)
//   in_data    operand k = in_data[k*WIDTH +: WIDTH]
//   in_op      0 AND,1 OR,2 XOR,3 NAND,4 NOR,5 XNOR,6 ACC_OR,7 ACC_XOR
//   acc_clr    clear accumulator (no handshake)
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   result
//   out_zero   out_data == 0
//   acc_value  current accumulator contents
module logic_gate_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              in_op,
  input  logic                    acc_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_zero,
  output logic [WIDTH-1:0]        acc_value
);

  typedef enum logic [2:0] {
    OP_AND     = 3'd0,
    OP_OR      = 3'd1,
    OP_XOR     = 3'd2,
    OP_NAND    = 3'd3,
    OP_NOR     = 3'd4,
    OP_XNOR    = 3'd5,
    OP_ACC_OR  = 3'd6,
    OP_ACC_XOR = 3'd7
  } op_e;

  op_e              w_op;
  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_xor;
  logic [WIDTH-1:0] w_acc_eff;
  logic [WIDTH-1:0] w_result;
  logic             w_is_acc;
  logic             w_s1_adv;
  logic             w_s2_adv;
  logic             w_accept;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_data;
  logic             r_s2_zero;
  logic [WIDTH-1:0] r_acc;

  assign w_op = op_e'(in_op);

  // Full reductions; the inverting ops invert these, not a pairwise chain.
  always_comb begin
    w_and = '1;
    w_or  = '0;
    w_xor = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      w_and = w_and & in_data[k*WIDTH +: WIDTH];
      w_or  = w_or  | in_data[k*WIDTH +: WIDTH];
      w_xor = w_xor ^ in_data[k*WIDTH +: WIDTH];
    end
  end

  // A clear in the same cycle as an ACC accept applies before the fold.
  assign w_acc_eff = acc_clr ? '0 : r_acc;
  assign w_is_acc  = (w_op == OP_ACC_OR) || (w_op == OP_ACC_XOR);

  always_comb begin
    w_result = '0;
    case (w_op)
      OP_AND:     w_result = w_and;
      OP_OR:      w_result = w_or;
      OP_XOR:     w_result = w_xor;
      OP_NAND:    w_result = ~w_and;
      OP_NOR:     w_result = ~w_or;
      OP_XNOR:    w_result = ~w_xor;
      OP_ACC_OR:  w_result = w_acc_eff | w_or;
      OP_ACC_XOR: w_result = w_acc_eff ^ w_xor;
    endcase
  end

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;
  assign w_accept = in_valid && w_s1_adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_zero  <= 1'b1;
      r_acc      <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_data <= w_result;
        end
      end
      // Output registers only load when a valid item moves in, so they hold
      // their value through a stall.
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= r_s1_data;
          r_s2_zero <= (r_s1_data == '0);
        end
      end
      if (w_accept && w_is_acc) begin
        r_acc <= w_result;
      end else if (acc_clr) begin
        r_acc <= '0;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_zero  = r_s2_zero;
  assign acc_value = r_acc;

endmodule
